pulse_group_sequencer: RTL

PULSE_GROUP_SEQUENCER -- requirements
Module: pulse_group_sequencer

---
 rtl/pulse_group_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pulse_group_sequencer.sv
// Laser pulse-group sequencer: counts synchronized trigger edges into a group
// of TOTAL_PULSE pulses and opens a WINDOW_LEN-cycle capture window per pulse.
module pulse_group_sequencer #(
    parameter int unsigned TOTAL_PULSE = 4,
    parameter int unsigned WINDOW_LEN  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        trig_in,
    output logic [15:0] Pulse_counts,
    output logic        Capture_Window,
    output logic [15:0] Sample_Index,
    output logic        Busy,
    output logic        Group_Done,
    output logic        Trig_Overrun
);

    localparam logic [15:0] LP_TOTAL    = 16'(TOTAL_PULSE);
    localparam logic [15:0] LP_WIN_LAST = 16'(WINDOW_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_WINDOW = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [1:0]  r_rst_sync;
    logic        r_trig_s1;
    logic        r_trig_s2;
    logic        r_trig_s3;
    logic [15:0] r_pulse_cnt;
    logic [15:0] r_sample_idx;
    logic        r_overrun;

    logic        w_run;
    logic        w_trig_evt;
    logic        w_start_acc;
    logic        w_win_last;
    logic        w_cnt_full;

    // Reset release is re-timed so commands and triggers are only honoured
    // once the design has seen two clean edges out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
            r_trig_s1  <= 1'b0;
            r_trig_s2  <= 1'b0;
            r_trig_s3  <= 1'b0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
            r_trig_s1  <= trig_in;
            r_trig_s2  <= r_trig_s1;
            r_trig_s3  <= r_trig_s2;
        end
    end

    assign w_run       = r_rst_sync[1];
    assign w_trig_evt  = r_trig_s2 & ~r_trig_s3 & w_run;
    assign w_start_acc = start & ~abort & w_run & (r_state == S_IDLE);
    assign w_win_last  = (r_sample_idx == LP_WIN_LAST);
    assign w_cnt_full  = (r_pulse_cnt >= LP_TOTAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_next_state = S_ARMED;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_trig_evt && !w_cnt_full) begin
                    w_next_state = S_WINDOW;
                end
            end
            S_WINDOW: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_win_last) begin
                    w_next_state = w_cnt_full ? S_DONE : S_ARMED;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Count, sample offset and overrun flag advance alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt  <= 16'd0;
            r_sample_idx <= 16'd0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_pulse_cnt <= 16'd0;
            end else if ((r_state == S_ARMED) && !abort && w_trig_evt && !w_cnt_full) begin
                r_pulse_cnt <= r_pulse_cnt + 16'd1;
            end

            if ((r_state == S_WINDOW) && !abort && !w_win_last) begin
                r_sample_idx <= r_sample_idx + 16'd1;
            end else begin
                r_sample_idx <= 16'd0;
            end

            if (w_start_acc) begin
                r_overrun <= 1'b0;
            end else if ((r_state == S_WINDOW) && w_trig_evt) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        Pulse_counts   = r_pulse_cnt;
        Sample_Index   = r_sample_idx;
        Trig_Overrun   = r_overrun;
        Capture_Window = (r_state == S_WINDOW);
        Busy           = (r_state != S_IDLE);
        Group_Done     = (r_state == S_DONE);
    end

endmodule
